// File: rtl/ecg_stage_sequencer.sv
// Purpose: steps one ECG sample through NUM_STAGES processing stages, one start pulse per stage.
// Latency: sample_valid_i -> stage_start_o[0] next cycle; last done edge -> sample_done_o next cycle.
// Backpressure: one pending sample is buffered while busy; further samples drop and set overrun_o.
// Optional per-stage WAIT timeout is enabled by defining SEQ_TIMEOUT_EN.
module ecg_stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int IDX_W      = 2,
    parameter int TMO_W      = 16,
    parameter int TMO_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid_i,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic [NUM_STAGES-1:0] stage_start_o,
    output logic [IDX_W-1:0]      stage_idx_o,
    output logic                  busy_o,
    output logic                  sample_done_o,
    output logic                  overrun_o,
    output logic                  timeout_o,
    output logic [IDX_W-1:0]      err_stage_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    if (NUM_STAGES < 2 || NUM_STAGES > 2**IDX_W || TMO_CYCLES < 1 || TMO_CYCLES >= 2**TMO_W) begin : g_bad_params
        $error("ecg_stage_sequencer: illegal parameter combination");
    end

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    pending;
    logic                    flag;
    logic [NUM_STAGES-1:0]   prev;
    logic                    overrun;
    logic [NUM_STAGES-1:0]   rise;
    logic                    cur_edge;
    logic                    last_stage;

    assign rise       = stage_done_i & ~prev;
    assign cur_edge   = rise[idx];
    assign last_stage = (idx == IDX_W'(NUM_STAGES - 1));

`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;
    logic [IDX_W-1:0] err_q;
    assign timeout_o   = timeout_q;
    assign err_stage_o = err_q;
`else
    assign timeout_o   = 1'b0;
    assign err_stage_o = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            flag    <= 1'b0;
            prev    <= '0;
            overrun <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
`endif
        end else begin
            prev <= stage_done_i;
            // Samples arriving while busy go to the single pending slot; a full slot drops them.
            if (sample_valid_i && state != IDLE) begin
                if (!pending) pending <= 1'b1;
                else          overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_valid_i || pending) begin
                        state   <= ISSUE;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                ISSUE: begin
                    flag  <= cur_edge;
                    state <= WAIT;
`ifdef SEQ_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (flag || cur_edge) begin
                        flag <= 1'b0;
                        if (last_stage) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ISSUE;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
                        state     <= DONE;
                        timeout_q <= 1'b1;
                        pending   <= 1'b0;
                        if (!timeout_q) err_q <= idx;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                DONE: begin
                    idx <= '0;
                    // A sample arriving now is consumed directly instead of parking in the slot.
                    pending <= 1'b0;
                    if (pending || sample_valid_i) state <= ISSUE;
                    else                           state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stage_start_o = (state == ISSUE) ? (NUM_STAGES'(1) << idx) : '0;
    assign stage_idx_o   = idx;
    assign busy_o        = (state != IDLE);
    assign sample_done_o = (state == DONE);
    assign overrun_o     = overrun;

endmodule

// File: tb/tb_ecg_stage_sequencer.sv
// Bench for ecg_stage_sequencer: expected start/done events are queued when stimulus is driven.
module tb_ecg_stage_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_valid_i;
    logic [3:0] stage_done_i;
    logic [3:0] stage_start_o;
    logic [1:0] stage_idx_o;
    logic       busy_o;
    logic       sample_done_o;
    logic       overrun_o;
    logic       timeout_o;
    logic [1:0] err_stage_o;

    ecg_stage_sequencer #(
        .NUM_STAGES(4), .IDX_W(2), .TMO_W(16), .TMO_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid_i(sample_valid_i),
        .stage_done_i(stage_done_i), .stage_start_o(stage_start_o),
        .stage_idx_o(stage_idx_o), .busy_o(busy_o), .sample_done_o(sample_done_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o), .err_stage_o(err_stage_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_done;
        int idx;
    } ev_t;
    ev_t exp_q[$];

    typedef struct packed {
        logic [3:0][7:0] lat;      // done rises lat[i] cycles after start[i]
        logic [7:0]      exp_done; // sample_done_o cycle relative to the valid cycle
    } vec_t;
    vec_t vecs[4];

    int checks = 0;
    int failures = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (stage_start_o != 4'd0 || sample_done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: start=%b sample_done=%b at cycle %0d, expected none",
                         stage_start_o, sample_done_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_kind", int'(sample_done_o), int'(e.is_done));
                if (!e.is_done) begin
                    check("start_onehot", int'(stage_start_o), 1 << e.idx);
                    check("stage_idx", int'(stage_idx_o), e.idx);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic push_ev(int c, bit d, int i);
        ev_t e;
        e.cyc = c; e.is_done = d; e.idx = i;
        exp_q.push_back(e);
    endtask

    task automatic push_chain(int s0, logic [3:0][7:0] lat, int done_cyc);
        int s = s0;
        for (int i = 0; i < 4; i++) begin
            push_ev(s, 1'b0, i);
            s = s + int'(lat[i]) + 1;
        end
        push_ev(done_cyc, 1'b1, 0);
    endtask

    task automatic respond_chain(int s0, logic [3:0][7:0] lat);
        int s = s0;
        for (int i = 0; i < 4; i++) begin
            wait_until(s + int'(lat[i]));
            stage_done_i[i] = 1'b1;
            tick();
            stage_done_i[i] = 1'b0;
            s = s + int'(lat[i]) + 1;
        end
    endtask

    task automatic run_vec(vec_t v, string name);
        int t0 = cyc;
        push_chain(t0 + 1, v.lat, t0 + int'(v.exp_done));
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        respond_chain(t0 + 1, v.lat);
        wait_until(t0 + int'(v.exp_done) + 1);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, int'(busy_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vecs[0] = '{lat: {8'd3, 8'd3, 8'd3, 8'd3}, exp_done: 8'd17};
        vecs[1] = '{lat: {8'd1, 8'd1, 8'd1, 8'd1}, exp_done: 8'd9};
        vecs[2] = '{lat: {8'd3, 8'd1, 8'd5, 8'd2}, exp_done: 8'd16};
        vecs[3] = '{lat: {8'd6, 8'd2, 8'd1, 8'd4}, exp_done: 8'd18};

        // Reset with valid and all done lines high
        reset_n = 1'b0;
        sample_valid_i = 1'b1;
        stage_done_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_start", int'(stage_start_o), 0);
            check("rst_idx", int'(stage_idx_o), 0);
            check("rst_busy", int'(busy_o), 0);
            check("rst_sample_done", int'(sample_done_o), 0);
            check("rst_overrun", int'(overrun_o), 0);
            check("rst_timeout", int'(timeout_o), 0);
            check("rst_err_stage", int'(err_stage_o), 0);
        end
        sample_valid_i = 1'b0;
        stage_done_i = 4'h0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", int'(busy_o), 0);

        for (int v = 0; v < 4; v++) run_vec(vecs[v], "vec");

        // Two extra samples while busy: one queued, one dropped
        t0 = cyc;
        push_chain(t0 + 1, vecs[0].lat, t0 + 17);
        push_chain(t0 + 18, vecs[0].lat, t0 + 34);
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        fork
            respond_chain(t0 + 1, vecs[0].lat);
            begin
                wait_until(t0 + 3);
                sample_valid_i = 1'b1;
                tick();
                sample_valid_i = 1'b0;
                check("overrun_after_2nd", int'(overrun_o), 0);
                wait_until(t0 + 5);
                sample_valid_i = 1'b1;
                tick();
                sample_valid_i = 1'b0;
                check("overrun_after_3rd", int'(overrun_o), 1);
            end
        join
        respond_chain(t0 + 18, vecs[0].lat);
        wait_until(t0 + 45);
        check("ovr_drained", exp_q.size(), 0);
        check("ovr_idle", int'(busy_o), 0);
        check("ovr_sticky", int'(overrun_o), 1);

        // Done level already high when its stage starts: needs a fresh rise
        t0 = cyc;
        push_ev(t0 + 1, 1'b0, 0);
        push_ev(t0 + 4, 1'b0, 1);
        push_ev(t0 + 7, 1'b0, 2);
        push_ev(t0 + 15, 1'b0, 3);
        push_ev(t0 + 18, 1'b1, 0);
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        wait_until(t0 + 3);
        stage_done_i[0] = 1'b1;
        tick();
        stage_done_i[0] = 1'b0;
        wait_until(t0 + 5);
        stage_done_i[2] = 1'b1;
        tick();
        stage_done_i[1] = 1'b1;
        tick();
        stage_done_i[1] = 1'b0;
        wait_until(t0 + 11);
        check("held_idx", int'(stage_idx_o), 2);
        check("held_busy", int'(busy_o), 1);
        wait_until(t0 + 12);
        stage_done_i[2] = 1'b0;
        wait_until(t0 + 14);
        stage_done_i[2] = 1'b1;
        tick();
        stage_done_i[2] = 1'b0;
        wait_until(t0 + 17);
        stage_done_i[3] = 1'b1;
        tick();
        stage_done_i[3] = 1'b0;
        wait_until(t0 + 19);
        check("held_drained", exp_q.size(), 0);

        // Reset mid-WAIT at stage 2 with a pending sample
        t0 = cyc;
        push_ev(t0 + 1, 1'b0, 0);
        push_ev(t0 + 5, 1'b0, 1);
        push_ev(t0 + 9, 1'b0, 2);
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        wait_until(t0 + 3);
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        stage_done_i[0] = 1'b1;
        tick();
        stage_done_i[0] = 1'b0;
        wait_until(t0 + 8);
        stage_done_i[1] = 1'b1;
        tick();
        stage_done_i[1] = 1'b0;
        wait_until(t0 + 11);
        check("pre_rst_idx", int'(stage_idx_o), 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_busy", int'(busy_o), 0);
        check("mid_rst_idx", int'(stage_idx_o), 0);
        check("mid_rst_overrun", int'(overrun_o), 0);
        wait_until(t0 + 22);
        check("mid_rst_no_pending_run", exp_q.size(), 0);
        run_vec(vecs[1], "restart");

`ifdef SEQ_TIMEOUT_EN
        // Stage 1 never completes: abort after 8 WAIT cycles
        t0 = cyc;
        push_ev(t0 + 1, 1'b0, 0);
        push_ev(t0 + 4, 1'b0, 1);
        push_ev(t0 + 13, 1'b1, 0);
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        wait_until(t0 + 3);
        stage_done_i[0] = 1'b1;
        tick();
        stage_done_i[0] = 1'b0;
        wait_until(t0 + 12);
        check("tmo_not_yet", int'(timeout_o), 0);
        wait_until(t0 + 14);
        check("tmo_flag", int'(timeout_o), 1);
        check("tmo_err_stage", int'(err_stage_o), 1);
        check("tmo_idle", int'(busy_o), 0);
        check("tmo_drained", exp_q.size(), 0);
`else
        check("no_tmo_flag", int'(timeout_o), 0);
        check("no_tmo_err_stage", int'(err_stage_o), 0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
